// File: rtl/piece_queue.sv
// Piece queue: filters randomizer samples into legal piece IDs, buffers them in a small FIFO
// and hands one piece per spawn request to the game FSM with a one-cycle acknowledge.
module piece_queue #(
  parameter int unsigned Depth        = 3,
  parameter int unsigned NumPieces    = 3,
  parameter int unsigned MaxRepeatRej = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] random_i,
  input  logic       spawn_req_i,
  output logic       spawn_ack_o,
  output logic [1:0] spawn_piece_o,
  output logic [1:0] preview_o,
  output logic       preview_valid_o,
  output logic [2:0] count_o,
  output logic       full_o
);

  localparam int unsigned PtrW = (Depth > 2) ? $clog2(Depth) : 1;
  localparam int unsigned RepW = $clog2(MaxRepeatRej + 1);
  localparam logic [2:0] NumPiecesW = 3'(NumPieces);
  localparam logic [2:0] DepthW     = 3'(Depth);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mem_q [Depth];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [2:0]        count_q, count_d;
  logic [1:0]        last_q;
  logic              last_valid_q;
  logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;
  logic              ack_q;
  logic [1:0]        piece_q;
  logic              sample_en, push, pop;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StFill;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (push && !pop && (count_q == DepthW - 3'd1)) state_d = StFull;
      StFull: if (pop) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Output logic
  always_comb begin
    sample_en = (state_q == StFill);
  end

  // Sample filter: reject illegal IDs, and repeats until MaxRepeatRej rejects have piled up.
  always_comb begin
    push      = 1'b0;
    rep_cnt_d = rep_cnt_q;
    if (sample_en && ({1'b0, random_i} < NumPiecesW)) begin
      if (last_valid_q && (random_i == last_q) && (rep_cnt_q < RepW'(MaxRepeatRej))) begin
        rep_cnt_d = rep_cnt_q + RepW'(1);
      end else begin
        push      = 1'b1;
        rep_cnt_d = '0;
      end
    end
  end

  // No pop while the previous ack is still high; an empty queue leaves the request pending.
  assign pop = spawn_req_i && (count_q != 3'd0) && !ack_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= 3'd0;
      last_q       <= 2'd0;
      last_valid_q <= 1'b0;
      rep_cnt_q    <= '0;
      ack_q        <= 1'b0;
      piece_q      <= 2'd0;
    end else begin
      count_q   <= count_d;
      rep_cnt_q <= rep_cnt_d;
      ack_q     <= pop;
      if (push) begin
        mem_q[tail_q] <= random_i;
        tail_q        <= (tail_q == PtrW'(Depth - 1)) ? '0 : tail_q + PtrW'(1);
        last_q        <= random_i;
        last_valid_q  <= 1'b1;
      end
      if (pop) begin
        piece_q <= mem_q[head_q];
        head_q  <= (head_q == PtrW'(Depth - 1)) ? '0 : head_q + PtrW'(1);
      end
    end
  end

  assign spawn_ack_o     = ack_q;
  assign spawn_piece_o   = piece_q;
  assign preview_o       = mem_q[head_q];
  assign preview_valid_o = (count_q != 3'd0);
  assign count_o         = count_q;
  assign full_o          = (count_q == DepthW);

endmodule
